// File: rtl/bla_subtractor_16bit_pipe.sv
// 16-bit borrow-lookahead subtractor, two register stages split
// after bit 7, valid/ready on both sides.
package bla_sub_pkg;

  typedef struct packed {
    logic [7:0] d_lo;
    logic       br8;
    logic [7:0] a_hi;
    logic [7:0] b_hi;
    logic       a15;
    logic       b15;
  } s1_t;

  typedef struct packed {
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
  } s2_t;

endpackage

module bla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       br_in,
  output logic [3:0] d,
  output logic       br_out
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:1] br;

  assign g = ~a & b;
  assign p = ~(a ^ b);

  // two-level sum-of-products per borrow, no ripple
  assign br[1] = g[0]
               | (p[0] & br_in);
  assign br[2] = g[1]
               | (p[1] & g[0])
               | (p[1] & p[0] & br_in);
  assign br[3] = g[2]
               | (p[2] & g[1])
               | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & br_in);
  assign br[4] = g[3]
               | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & br_in);

  assign d      = a ^ b ^ {br[3:1], br_in};
  assign br_out = br[4];

endmodule

module bla_lo_stage
  import bla_sub_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  output s1_t         s1
);

  logic [7:0] d_lo;
  logic       br4;
  logic       br8;

  bla_group4 u_g0 (
    .a      (a[3:0]),
    .b      (b[3:0]),
    .br_in  (bin),
    .d      (d_lo[3:0]),
    .br_out (br4)
  );

  bla_group4 u_g1 (
    .a      (a[7:4]),
    .b      (b[7:4]),
    .br_in  (br4),
    .d      (d_lo[7:4]),
    .br_out (br8)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
    end else if (load) begin
      s1.d_lo <= d_lo;
      s1.br8  <= br8;
      s1.a_hi <= a[15:8];
      s1.b_hi <= b[15:8];
      s1.a15  <= a[15];
      s1.b15  <= b[15];
    end
  end

endmodule

module bla_hi_stage
  import bla_sub_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  s1_t  s1,
  output s2_t  s2
);

  logic [7:0]  d_hi;
  logic        br12;
  logic        br16;
  logic [15:0] diff;

  bla_group4 u_g2 (
    .a      (s1.a_hi[3:0]),
    .b      (s1.b_hi[3:0]),
    .br_in  (s1.br8),
    .d      (d_hi[3:0]),
    .br_out (br12)
  );

  bla_group4 u_g3 (
    .a      (s1.a_hi[7:4]),
    .b      (s1.b_hi[7:4]),
    .br_in  (br12),
    .d      (d_hi[7:4]),
    .br_out (br16)
  );

  assign diff = {d_hi, s1.d_lo};

  always_ff @(posedge clk) begin
    if (rst) begin
      s2 <= '0;
    end else if (load) begin
      s2.diff <= diff;
      s2.bout <= br16;
      s2.ovf  <= (s1.a15 != s1.b15)
               & (diff[15] != s1.a15);
      s2.zero <= (diff == 16'h0000);
    end
  end

endmodule

module bla_subtractor_16bit_pipe
  import bla_sub_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] diff,
  output logic        bout,
  output logic        ovf,
  output logic        zero,
  output logic        out_valid,
  input  logic        out_ready
);

  s1_t  s1;
  s2_t  s2;
  logic s1_valid;
  logic s2_adv;
  logic s1_adv;
  logic in_fire;

  assign s2_adv   = !out_valid | out_ready;
  assign s1_adv   = s1_valid & s2_adv;
  assign in_ready = !rst & (!s1_valid | s2_adv);
  assign in_fire  = in_valid & in_ready;

  bla_lo_stage u_lo (
    .clk  (clk),
    .rst  (rst),
    .load (in_fire),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .s1   (s1)
  );

  bla_hi_stage u_hi (
    .clk  (clk),
    .rst  (rst),
    .load (s1_adv),
    .s1   (s1),
    .s2   (s2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (in_fire)
        s1_valid <= 1'b1;
      else if (s1_adv)
        s1_valid <= 1'b0;
      if (s2_adv)
        out_valid <= s1_valid;
    end
  end

  assign diff = s2.diff;
  assign bout = s2.bout;
  assign ovf  = s2.ovf;
  assign zero = s2.zero;

endmodule

// File: tb/tb_bla_subtractor_16bit_pipe.sv
// Directed and random checks of the pipelined subtractor
// against a queue-based reference scoreboard.
module tb_bla_subtractor_16bit_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;
  logic [18:0] sb[$];

  always #5 clk = ~clk;

  bla_subtractor_16bit_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  function automatic logic [18:0] model(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic        c
  );
    logic [16:0] r;
    logic        v;
    r = {1'b0, x} - {1'b0, y} - {16'h0, c};
    v = (x[15] != y[15]) && (r[15] != x[15]);
    return {r[15:0], r[16], v, (r[15:0] == 16'h0)};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock: score transfers seen before the edge, then step past it
  task automatic tick();
    logic [18:0] e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result", 32'({diff, bout, ovf, zero}), 32'(e));
      end
    end
    if (in_valid && in_ready)
      sb.push_back(model(a, b, bin));
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic        c
  );
    a        = x;
    b        = y;
    bin      = c;
    in_valid = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_fields", 32'({diff, bout, ovf, zero}), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // basic and latency
    drive(16'h0005, 16'h0003, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("lat_edge1", 32'(out_valid), 32'd0);
    tick();
    chk("lat_edge2", 32'(out_valid), 32'd1);
    chk("basic", 32'({diff, bout, ovf, zero}),
        32'({16'h0002, 1'b0, 1'b0, 1'b0}));
    tick();

    // directed corner vectors back to back
    drive(16'h0000, 16'h0001, 1'b0);
    tick();
    drive(16'h8000, 16'h0001, 1'b0);
    tick();
    drive(16'h1234, 16'h1233, 1'b1);
    tick();
    drive(16'h0100, 16'h0001, 1'b0);
    tick();
    drive(16'h0000, 16'hFFFF, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("dir_drained", 32'(sb.size()), 32'd0);

    // backpressure
    out_ready = 1'b0;
    drive(16'h0010, 16'h0001, 1'b0);
    tick();
    drive(16'h0020, 16'h0002, 1'b0);
    tick();
    drive(16'h0030, 16'h0003, 1'b0);
    chk("stall_ready", 32'(in_ready), 32'd0);
    tick();
    chk("stall_ready2", 32'(in_ready), 32'd0);
    chk("stall_hold", 32'(diff), 32'h000F);
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_depth", 32'(sb.size()), 32'd2);
    out_ready = 1'b1;
    #1;
    chk("release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("release_q", 32'(sb.size()), 32'd2);
    tick();
    tick();
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // random stream at full rate
    for (int i = 0; i < 16; i++) begin
      drive(16'($urandom), 16'($urandom),
            1'($urandom_range(1, 0)));
      #1;
      chk("stream_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("stream_drained", 32'(sb.size()), 32'd0);

    // reset with two beats in flight
    out_ready = 1'b0;
    drive(16'h4444, 16'h1111, 1'b0);
    tick();
    drive(16'h5555, 16'h1111, 1'b0);
    tick();
    drive(16'h6666, 16'h1111, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(in_ready), 32'd0);
    tick();
    sb.delete();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_fields", 32'({diff, bout, ovf, zero}), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("midrst_ready_after", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_stale", 32'(out_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
